doorbell_alert_ctrl: RTL and testbench
======================================

// Module: doorbell_alert_ctrl
// PURPOSE
//  Parametrised successor to the doorbell top: N threshold sensor channels plus button, each
//  with consecutive-sample confirmation, feeding a timed alert FSM (IDLE/ALERT/COOLDOWN).
//  Drives LED, pulsed vibration, light, camera enable, latched event source, alert count.
//  Sits between sensor front-ends and indicator pins.
// PARAMETERS
//  DATA_W          8     sample/threshold width
//  NUM_CH          2     sensor channels (ch0 knock, ch1 mic by convention)
//  CONFIRM_CYCLES  4     consecutive above-threshold/pressed cycles to confirm (>=1)
//  ALERT_CYCLES    1000  ALERT dwell after last trigger (>=2)
//  VIBE_HALF       50    vibration half-period in cycles (>=1)
//  COOLDOWN_CYCLES 500   trigger-blind period after ALERT (>=1)
// PORTS
//  clk           in   1              clock
//  reset         in   1              synchronous, active-high reset
//  sample_in     in   NUM_CH*DATA_W  channel samples, ch i at [i*DATA_W +: DATA_W]
//  thr_in        in   NUM_CH*DATA_W  per-channel thresholds, same packing, static
//  ch_enable     in   NUM_CH         per-channel enable; disabled channel never triggers
//  button        in   1              doorbell button, already synchronous to clk
//  led           out  1              alert indicator
//  vibration     out  1              pulsed during ALERT
//  light_output  out  1              ~led
//  camera_active out  1              see CONFIGURATION
//  event_src     out  NUM_CH+1       latched sources of current alert; bit NUM_CH = button
//  alert_count   out  16             saturating IDLE->ALERT count
// BEHAVIOUR
//  Reset (sync, clk edge with reset=1, also mid-operation): state IDLE, all counters/timers 0,
//   led=0, vibration=0, light_output=1, event_src=0, alert_count=0; effect visible next cycle.
//  Channel: hit_i = ch_enable[i] && sample_i > thr_i (strict, unsigned). Counter +1 per hit
//   cycle, saturates at CONFIRM_CYCLES, clears to 0 on any non-hit. det_i = (cnt==CONFIRM_CYCLES).
//   Button uses identical counter with hit=button. trigger = |det.
//  Latency: hit first presented in cycle 0 -> det high after edge CONFIRM_CYCLES -> led=1 after
//   edge CONFIRM_CYCLES+1. led, vibration, light_output, event_src are registered.
//  IDLE: trigger -> ALERT; timer=ALERT_CYCLES-1, event_src=det, alert_count+1 (hold at FFFF),
//   vibration=1, vib phase counter=0.
//  ALERT: led=1. trigger reloads timer to ALERT_CYCLES-1 (reload wins over exit on final cycle)
//   and ORs det into event_src. Else timer-1; at 0 -> COOLDOWN, timer=COOLDOWN_CYCLES-1.
//   vibration toggles every VIBE_HALF cycles in ALERT; forced 0 outside ALERT.
//  COOLDOWN: led=0, vibration=0, triggers ignored (no reload, no count); at timer 0 -> IDLE.
//   Channel counters keep running; a trigger still held enters ALERT on the first IDLE cycle.
//  event_src holds through COOLDOWN and IDLE until the next IDLE->ALERT load.
//  Timer width $clog2(max(ALERT_CYCLES,COOLDOWN_CYCLES)+1); no wrap, never below 0.
// CONFIGURATION
//  DOORBELL_CAMERA_GATE_EN defined: camera_active registered, 1 in ALERT and COOLDOWN,
//   0 in IDLE and during/after reset.
//  Not defined: camera_active tied 1'b1 always, including during reset.
// STRUCTURE
//  Package doorbell_pkg: state enum {ST_IDLE, ST_ALERT, ST_COOLDOWN}, ALERT_CNT_W=16.
//  Sub-module doorbell_chan_confirm (compare + saturating confirm counter, DATA_W/CONFIRM_CYCLES,
//   bypass-compare mode for button); NUM_CH+1 instances via generate.
// TESTING (defaults, thr ch0=75 ch1=150)
//  1 ch0 sample 76 for 4 cycles -> led=1 after edge 5, event_src=3'b001, alert_count=1.
//  2 ch0 sample 75 held 20 cycles -> led stays 0 (strict compare); 76 for 3 cycles then 0 -> no alert.
//  3 button 1 cycle at ALERT timer=0 -> stays ALERT, timer reloads, event_src |= 3'b100.
//  4 In COOLDOWN drive ch1=200 -> no reload, alert_count unchanged; held -> ALERT on first IDLE cycle.
//  5 In ALERT, vibration period = 100 cycles; reset mid-ALERT -> next cycle led=0, vibration=0,
//    light_output=1, count=0.
//  6 ch_enable=0 with ch0=255 -> no alert; 65536 alerts -> alert_count saturates 16'hFFFF;
//    run with/without DOORBELL_CAMERA_GATE_EN checking camera_active.

Source files
------------

// File: rtl/doorbell_pkg.sv
// Shared types and constants for the doorbell alert controller.
package doorbell_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALERT,
    ST_COOLDOWN
  } state_t;

  localparam int ALERT_CNT_W = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/doorbell_chan_confirm.sv
// One confirmation channel: strict unsigned threshold compare (or raw hit in bypass
// mode) feeding a saturating consecutive-hit counter; o_det is high while saturated.
module doorbell_chan_confirm
  import doorbell_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int CONFIRM_CYCLES = 4,
  parameter bit BYPASS         = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [DATA_W-1:0] i_thr,
  input  logic              i_hit_en,
  output logic              o_det
);

  localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CONFIRM_CYCLES);

  logic             w_above;
  logic             w_hit;
  logic [CNT_W-1:0] r_cnt;

  assign w_above = (i_sample > i_thr);
  assign w_hit   = i_hit_en && (BYPASS || w_above);

  // confirm counter stage: any non-hit cycle restarts the run
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!w_hit) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_SAT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_det = (r_cnt == CNT_SAT);

endmodule

// File: rtl/doorbell_alert_ctrl.sv
// Doorbell alert controller: NUM_CH sensor channels plus button, confirmed, driving an
// IDLE/ALERT/COOLDOWN FSM. Define DOORBELL_CAMERA_GATE_EN to gate camera_active by state.
module doorbell_alert_ctrl
  import doorbell_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int NUM_CH          = 2,
  parameter int CONFIRM_CYCLES  = 4,
  parameter int ALERT_CYCLES    = 1000,
  parameter int VIBE_HALF       = 50,
  parameter int COOLDOWN_CYCLES = 500
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  input  logic [NUM_CH*DATA_W-1:0] thr_in,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     button,
  output logic                     led,
  output logic                     vibration,
  output logic                     light_output,
  output logic                     camera_active,
  output logic [NUM_CH:0]          event_src,
  output logic [ALERT_CNT_W-1:0]   alert_count
);

  localparam int TMR_W = $clog2(max_int(ALERT_CYCLES, COOLDOWN_CYCLES) + 1);
  localparam int VIB_W = $clog2(VIBE_HALF + 1);
  localparam logic [TMR_W-1:0] ALERT_LOAD = TMR_W'(ALERT_CYCLES - 1);
  localparam logic [TMR_W-1:0] COOL_LOAD  = TMR_W'(COOLDOWN_CYCLES - 1);
  localparam logic [VIB_W-1:0] VIB_LAST   = VIB_W'(VIBE_HALF - 1);

  function automatic logic [ALERT_CNT_W-1:0] sat_inc(input logic [ALERT_CNT_W-1:0] v);
    return (v == '1) ? v : v + ALERT_CNT_W'(1);
  endfunction

  logic [NUM_CH:0] w_det;
  logic            w_trigger;

  // confirmation stage
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    doorbell_chan_confirm #(
      .DATA_W        (DATA_W),
      .CONFIRM_CYCLES(CONFIRM_CYCLES),
      .BYPASS        (1'b0)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .i_sample(sample_in[g*DATA_W +: DATA_W]),
      .i_thr   (thr_in[g*DATA_W +: DATA_W]),
      .i_hit_en(ch_enable[g]),
      .o_det   (w_det[g])
    );
  end

  doorbell_chan_confirm #(
    .DATA_W        (DATA_W),
    .CONFIRM_CYCLES(CONFIRM_CYCLES),
    .BYPASS        (1'b1)
  ) u_button (
    .clk     (clk),
    .reset   (reset),
    .i_sample('0),
    .i_thr   ('0),
    .i_hit_en(button),
    .o_det   (w_det[NUM_CH])
  );

  assign w_trigger = |w_det;

  state_t                 r_state, w_state_nxt;
  logic [TMR_W-1:0]       r_timer, w_timer_nxt;
  logic [VIB_W-1:0]       r_vib_ph, w_vib_ph_nxt;
  logic                   r_vib, w_vib_nxt;
  logic                   r_led, w_led_nxt;
  logic                   r_light;
  logic [NUM_CH:0]        r_evsrc, w_evsrc_nxt;
  logic [ALERT_CNT_W-1:0] r_alert_count, w_alert_count_nxt;

  // FSM next-state stage
  always_comb begin
    w_state_nxt       = r_state;
    w_timer_nxt       = r_timer;
    w_vib_ph_nxt      = r_vib_ph;
    w_vib_nxt         = r_vib;
    w_led_nxt         = r_led;
    w_evsrc_nxt       = r_evsrc;
    w_alert_count_nxt = r_alert_count;
    case (r_state)
      ST_IDLE: begin
        w_led_nxt = 1'b0;
        w_vib_nxt = 1'b0;
        if (w_trigger) begin
          w_state_nxt       = ST_ALERT;
          w_timer_nxt       = ALERT_LOAD;
          w_evsrc_nxt       = w_det;
          w_alert_count_nxt = sat_inc(r_alert_count);
          w_vib_nxt         = 1'b1;
          w_vib_ph_nxt      = '0;
          w_led_nxt         = 1'b1;
        end
      end
      ST_ALERT: begin
        w_led_nxt = 1'b1;
        if (r_vib_ph == VIB_LAST) begin
          w_vib_ph_nxt = '0;
          w_vib_nxt    = ~r_vib;
        end else begin
          w_vib_ph_nxt = r_vib_ph + VIB_W'(1);
        end
        // a trigger on the final cycle reloads instead of exiting
        if (w_trigger) begin
          w_timer_nxt = ALERT_LOAD;
          w_evsrc_nxt = r_evsrc | w_det;
        end else if (r_timer == '0) begin
          w_state_nxt  = ST_COOLDOWN;
          w_timer_nxt  = COOL_LOAD;
          w_led_nxt    = 1'b0;
          w_vib_nxt    = 1'b0;
          w_vib_ph_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      ST_COOLDOWN: begin
        w_led_nxt = 1'b0;
        w_vib_nxt = 1'b0;
        if (r_timer == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_led_nxt   = 1'b0;
        w_vib_nxt   = 1'b0;
      end
    endcase
  end

  // FSM register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_vib_ph      <= '0;
      r_vib         <= 1'b0;
      r_led         <= 1'b0;
      r_light       <= 1'b1;
      r_evsrc       <= '0;
      r_alert_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_vib_ph      <= w_vib_ph_nxt;
      r_vib         <= w_vib_nxt;
      r_led         <= w_led_nxt;
      r_light       <= ~w_led_nxt;
      r_evsrc       <= w_evsrc_nxt;
      r_alert_count <= w_alert_count_nxt;
    end
  end

  assign led          = r_led;
  assign vibration    = r_vib;
  assign light_output = r_light;
  assign event_src    = r_evsrc;
  assign alert_count  = r_alert_count;

`ifdef DOORBELL_CAMERA_GATE_EN
  logic r_cam;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cam <= 1'b0;
    end else begin
      r_cam <= (w_state_nxt != ST_IDLE);
    end
  end

  assign camera_active = r_cam;
`else
  assign camera_active = 1'b1;
`endif

endmodule

// File: tb/tb_doorbell_alert_ctrl.sv
// Self-checking bench for doorbell_alert_ctrl: vector table plus hand-written timing sequences.
module tb_doorbell_alert_ctrl;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] sample_in;
  logic [NUM_CH*DATA_W-1:0] thr_in;
  logic [NUM_CH-1:0]        ch_enable;
  logic                     button;
  logic                     led;
  logic                     vibration;
  logic                     light_output;
  logic                     camera_active;
  logic [NUM_CH:0]          event_src;
  logic [15:0]              alert_count;

  always #5 clk = ~clk;

  doorbell_alert_ctrl #(
    .DATA_W         (DATA_W),
    .NUM_CH         (NUM_CH),
    .CONFIRM_CYCLES (4),
    .ALERT_CYCLES   (1000),
    .VIBE_HALF      (50),
    .COOLDOWN_CYCLES(500)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .thr_in       (thr_in),
    .ch_enable    (ch_enable),
    .button       (button),
    .led          (led),
    .vibration    (vibration),
    .light_output (light_output),
    .camera_active(camera_active),
    .event_src    (event_src),
    .alert_count  (alert_count)
  );

  typedef struct {
    string       name;
    logic        led;
    logic        vib;
    logic        vib_care;
    logic [2:0]  ev;
    logic [15:0] cnt;
    logic        busy;
  } exp_t;

  typedef struct {
    string       name;
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic [1:0]  en;
    logic        btn;
    int          cyc;
    logic        led;
    logic        vib;
    logic [2:0]  ev;
    logic [15:0] cnt;
    logic        busy;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[10];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input string nm, input logic l, input logic v, input logic vc,
                          input logic [2:0] ev, input logic [15:0] cnt, input logic busy);
    exp_t e;
    e.name = nm; e.led = l; e.vib = v; e.vib_care = vc;
    e.ev = ev; e.cnt = cnt; e.busy = busy;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    logic exp_light;
    logic exp_cam;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb_q.pop_front();
    exp_light = ~e.led;
`ifdef DOORBELL_CAMERA_GATE_EN
    exp_cam = e.busy;
`else
    exp_cam = 1'b1;
`endif
    chk({e.name, ".led"}, led, e.led);
    chk({e.name, ".light"}, light_output, exp_light);
    if (e.vib_care) chk({e.name, ".vib"}, vibration, e.vib);
    chk({e.name, ".event_src"}, event_src, e.ev);
    chk({e.name, ".alert_count"}, alert_count, e.cnt);
    chk({e.name, ".camera"}, camera_active, exp_cam);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] s0, input logic [7:0] s1, input logic [1:0] en,
                       input logic btn);
    sample_in = {s1, s0};
    ch_enable = en;
    button    = btn;
  endtask

  function automatic vec_t mk(input string nm, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [1:0] en, input logic btn, input int cyc,
                              input logic l, input logic v, input logic [2:0] ev,
                              input logic [15:0] cnt, input logic busy);
    vec_t r;
    r.name = nm; r.s0 = s0; r.s1 = s1; r.en = en; r.btn = btn; r.cyc = cyc;
    r.led = l; r.vib = v; r.ev = ev; r.cnt = cnt; r.busy = busy;
    return r;
  endfunction

  initial begin
    tbl[0] = mk("thr_equal",    8'd75,  8'd0,   2'b11, 1'b0, 20, 1'b0, 1'b0, 3'b000, 16'd0, 1'b0);
    tbl[1] = mk("short_burst",  8'd76,  8'd0,   2'b11, 1'b0, 3,  1'b0, 1'b0, 3'b000, 16'd0, 1'b0);
    tbl[2] = mk("burst_break",  8'd0,   8'd0,   2'b11, 1'b0, 1,  1'b0, 1'b0, 3'b000, 16'd0, 1'b0);
    tbl[3] = mk("reburst3",     8'd76,  8'd0,   2'b11, 1'b0, 3,  1'b0, 1'b0, 3'b000, 16'd0, 1'b0);
    tbl[4] = mk("ch0_disabled", 8'd255, 8'd0,   2'b10, 1'b0, 10, 1'b0, 1'b0, 3'b000, 16'd0, 1'b0);
    tbl[5] = mk("ch1_equal",    8'd0,   8'd150, 2'b11, 1'b0, 10, 1'b0, 1'b0, 3'b000, 16'd0, 1'b0);
    tbl[6] = mk("btn_short",    8'd0,   8'd0,   2'b11, 1'b1, 3,  1'b0, 1'b0, 3'b000, 16'd0, 1'b0);
    tbl[7] = mk("btn_release",  8'd0,   8'd0,   2'b11, 1'b0, 1,  1'b0, 1'b0, 3'b000, 16'd0, 1'b0);
    tbl[8] = mk("ch0_confirm",  8'd76,  8'd0,   2'b11, 1'b0, 4,  1'b0, 1'b0, 3'b000, 16'd0, 1'b0);
    tbl[9] = mk("ch0_alert",    8'd0,   8'd0,   2'b11, 1'b0, 1,  1'b1, 1'b1, 3'b001, 16'd1, 1'b1);

    reset  = 1'b1;
    thr_in = {8'd150, 8'd75};
    drive(8'd0, 8'd0, 2'b11, 1'b0);
    push_exp("reset", 1'b0, 1'b0, 1'b1, 3'b000, 16'd0, 1'b0);
    step(2);
    pop_cmp();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].s0, tbl[i].s1, tbl[i].en, tbl[i].btn);
      push_exp(tbl[i].name, tbl[i].led, tbl[i].vib, 1'b1, tbl[i].ev, tbl[i].cnt, tbl[i].busy);
      step(tbl[i].cyc);
      pop_cmp();
    end

    // vibration: high 50 cycles from entry, low 50, high again
    push_exp("vib_hi_end", 1'b1, 1'b1, 1'b1, 3'b001, 16'd1, 1'b1);
    step(49); pop_cmp();
    push_exp("vib_lo_start", 1'b1, 1'b0, 1'b1, 3'b001, 16'd1, 1'b1);
    step(1);  pop_cmp();
    push_exp("vib_lo_end", 1'b1, 1'b0, 1'b1, 3'b001, 16'd1, 1'b1);
    step(49); pop_cmp();
    push_exp("vib_hi_again", 1'b1, 1'b1, 1'b1, 3'b001, 16'd1, 1'b1);
    step(1);  pop_cmp();

    // button confirmed exactly on the timer==0 cycle
    step(895);
    button = 1'b1;
    push_exp("alert_timer0", 1'b1, 1'b0, 1'b1, 3'b001, 16'd1, 1'b1);
    step(4); pop_cmp();
    button = 1'b0;
    push_exp("reload_at_0", 1'b1, 1'b1, 1'b1, 3'b101, 16'd1, 1'b1);
    step(1); pop_cmp();
    push_exp("alert_last", 1'b1, 1'b0, 1'b0, 3'b101, 16'd1, 1'b1);
    step(999); pop_cmp();
    push_exp("cooldown_in", 1'b0, 1'b0, 1'b1, 3'b101, 16'd1, 1'b1);
    step(1); pop_cmp();

    // triggers ignored in cooldown, then taken on the first idle cycle
    drive(8'd0, 8'd200, 2'b11, 1'b0);
    push_exp("cd_blind", 1'b0, 1'b0, 1'b1, 3'b101, 16'd1, 1'b1);
    step(10); pop_cmp();
    push_exp("cd_last", 1'b0, 1'b0, 1'b1, 3'b101, 16'd1, 1'b1);
    step(489); pop_cmp();
    push_exp("idle_one", 1'b0, 1'b0, 1'b1, 3'b101, 16'd1, 1'b0);
    step(1); pop_cmp();
    push_exp("realert_ch1", 1'b1, 1'b1, 1'b1, 3'b010, 16'd2, 1'b1);
    step(1); pop_cmp();
    push_exp("held_ch1", 1'b1, 1'b1, 1'b1, 3'b010, 16'd2, 1'b1);
    step(10); pop_cmp();

    // reset in the middle of an alert
    reset = 1'b1;
    drive(8'd0, 8'd0, 2'b11, 1'b0);
    push_exp("mid_reset", 1'b0, 1'b0, 1'b1, 3'b000, 16'd0, 1'b0);
    step(1); pop_cmp();
    reset = 1'b0;

    // saturation: preload the count just below the limit
    force dut.w_alert_count_nxt = 16'hFFFE;
    step(1);
    release dut.w_alert_count_nxt;
    push_exp("preload", 1'b0, 1'b0, 1'b1, 3'b000, 16'hFFFE, 1'b0);
    step(1); pop_cmp();
    button = 1'b1;
    push_exp("sat_first", 1'b1, 1'b1, 1'b1, 3'b100, 16'hFFFF, 1'b1);
    step(5); pop_cmp();
    button = 1'b0;
    push_exp("sat_idle", 1'b0, 1'b0, 1'b1, 3'b100, 16'hFFFF, 1'b0);
    step(1600); pop_cmp();
    button = 1'b1;
    push_exp("sat_hold", 1'b1, 1'b1, 1'b1, 3'b100, 16'hFFFF, 1'b1);
    step(5); pop_cmp();
    button = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
